// File: rtl/fp_mul_seq.sv
// Sequential IEEE-style floating-point multiplier: shift-add significand multiply, one bit per cycle.
// Define FP_MUL_SEQ_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a_operand,
  input  logic [EXP_W+MAN_W:0]     b_operand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     Exception,
  output logic                     Overflow,
  output logic                     Underflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 1;
  localparam int CW = $clog2(N + 1);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t            state, state_n;
  logic [W-1:0]      a_q;
  logic [EXP_W:0]    b_hdr;      // sign + exponent of B; its fraction lives in prod
  logic [2*N-1:0]    prod;
  logic [CW-1:0]     cnt;

  logic [N-1:0]      mcand;
  logic [N:0]        sum;
  logic              accept;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = MUL;
      end
      MUL:  if (cnt == CW'(MAN_W)) state_n = NORM;
      NORM: state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;
  assign mcand  = {1'b1, a_q[MAN_W-1:0]};
  assign sum    = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand} : '0);

  // Multiplier bits of B sit in the low half and are consumed LSB first as the
  // partial sum shifts in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_hdr <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_q   <= a_operand;
      b_hdr <= b_operand[W-1:MAN_W];
      prod  <= {{N{1'b0}}, 1'b1, b_operand[MAN_W-1:0]};
      cnt   <= '0;
    end else if (state == MUL) begin
      prod  <= {sum, prod[N-1:1]};
      cnt   <= cnt + 1'b1;
    end
  end

  // Normalise, round and classify
  logic                    msb, rnd, sgn;
  logic [MAN_W-1:0]        frac_t;
  logic [MAN_W:0]          frac_r;
  logic signed [XW-1:0]    ea, eb, exp_f;
  logic                    a_ones, b_ones, a_zero, b_zero;
  logic [W-1:0]            res_n;
  logic                    exc_n, ovf_n, unf_n;

  assign msb    = prod[2*N-1];
  assign frac_t = msb ? prod[2*N-2 -: MAN_W] : prod[2*N-3 -: MAN_W];

`ifdef FP_MUL_SEQ_RNE_EN
  logic guard, sticky;
  assign guard  = msb ? prod[N-1] : prod[N-2];
  assign sticky = msb ? |prod[N-2:0] : |prod[N-3:0];
  assign rnd    = guard & (sticky | frac_t[0]);
`else
  assign rnd    = 1'b0;
`endif

  assign frac_r = {1'b0, frac_t} + (MAN_W+1)'(rnd);
  assign ea     = {2'b00, a_q[W-2 -: EXP_W]};
  assign eb     = {2'b00, b_hdr[EXP_W-1:0]};
  // A rounding carry leaves the fraction all-zero, so only the exponent moves.
  assign exp_f  = ea + eb - BIAS + XW'(msb) + XW'(frac_r[MAN_W]);
  assign sgn    = a_q[W-1] ^ b_hdr[EXP_W];
  assign a_ones = &a_q[W-2 -: EXP_W];
  assign b_ones = &b_hdr[EXP_W-1:0];
  assign a_zero = ~|a_q[W-2 -: EXP_W];
  assign b_zero = ~|b_hdr[EXP_W-1:0];

  always_comb begin
    res_n = {sgn, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
    exc_n = 1'b0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (a_ones || b_ones) begin
      exc_n = 1'b1;
      res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      res_n = {sgn, {(W-1){1'b0}}};
    end else if (exp_f >= EMAX) begin
      ovf_n = 1'b1;
      res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_f <= 0) begin
      unf_n = 1'b1;
      res_n = {sgn, {(W-1){1'b0}}};
    end
  end

  // Results are only written in NORM, so they hold steady through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (state == NORM) begin
      result    <= res_n;
      Exception <= exc_n;
      Overflow  <= ovf_n;
      Underflow <= unf_n;
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: latency, results, flags, backpressure and mid-op reset.
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_operand, b_operand, result;
  logic        exc, ovf, unf;
  int          n_tests = 0;
  int          n_fail  = 0;

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Exception(exc), .Overflow(ovf), .Underflow(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // eflags = {Exception, Overflow, Underflow}
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [2:0] eflags, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a_operand = 32'hFFFF_FFFF;
    b_operand = 32'h1234_5678;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); lat++; #1;
    end
    chk({tag, ".lat"},   64'(lat),    64'd25);
    chk({tag, ".res"},   64'(result), 64'(er));
    chk({tag, ".flags"}, 64'({exc, ovf, unf}), 64'(eflags));
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      a_operand = 32'h3F80_0000;
      b_operand = 32'h3F80_0000;
      @(posedge clk); #1;
      chk({tag, ".hold_res"}, 64'(result), 64'(er));
      chk({tag, ".hold_ov"},  64'(out_valid), 64'd1);
      chk({tag, ".hold_ir"},  64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".ir_back"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    logic [31:0] exp035;
    logic        seen;
`ifdef FP_MUL_SEQ_RNE_EN
    exp035 = 32'h4040_0003;
`else
    exp035 = 32'h4040_0002;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_operand = '0; b_operand = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ov",    64'(out_valid), 64'd0);
    chk("rst.ir",    64'(in_ready),  64'd1);
    chk("rst.res",   64'(result),    64'd0);
    chk("rst.flags", 64'({exc, ovf, unf}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul5p6x3",  32'h40B3_3333, 32'h4040_0000, 32'h4186_6666, 3'b000, 0);
    run_op("hold",      32'h4010_0000, 32'h40F0_0000, 32'h4187_0000, 3'b000, 10);
    run_op("round",     32'h3FC0_0001, 32'h4000_0001, exp035,        3'b000, 0);
    run_op("ovf",       32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010, 0);
    run_op("unf",       32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001, 0);
    run_op("exc",       32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3'b100, 0);
    run_op("zero",      32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 3'b000, 0);
    run_op("exc_zero",  32'hFF80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b100, 0);

    // Reset in the middle of MUL must discard the operation
    @(negedge clk);
    in_valid = 1'b1; a_operand = 32'h4010_0000; b_operand = 32'h40F0_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.ov",  64'(out_valid), 64'd0);
    chk("midrst.ir",  64'(in_ready),  64'd1);
    chk("midrst.res", 64'(result),    64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst.no_out", 64'(seen), 64'd0);
    run_op("after_rst", 32'h4010_0000, 32'h40F0_0000, 32'h4187_0000, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
